// File: rtl/match_controller_pkg.sv
// match_pkg: shared definitions for the match controller slice.
//   - state_t encoding (also exported as 3-bit constants for legacy users)
//   - width helpers for the packed lives / scores / winner fields
//   - default frame-tick constants
package match_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAYING    = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  localparam logic [2:0] ST_IDLE       = 3'(IDLE);
  localparam logic [2:0] ST_COUNTDOWN  = 3'(COUNTDOWN);
  localparam logic [2:0] ST_PLAYING    = 3'(PLAYING);
  localparam logic [2:0] ST_ROUND_END  = 3'(ROUND_END);
  localparam logic [2:0] ST_MATCH_OVER = 3'(MATCH_OVER);

  localparam int DEF_RESPAWN_TICKS   = 60;
  localparam int DEF_COUNTDOWN_TICKS = 120;
  localparam int DEF_ROUND_END_TICKS = 90;
  localparam int DEF_ROUND_TICKS     = 3600;

  // Bits needed to hold 0..lives.
  function automatic int lives_width(input int lives);
    return $clog2(lives + 1);
  endfunction

  // Bits needed to hold 0..win_score.
  function automatic int score_width(input int win_score);
    return $clog2(win_score + 1);
  endfunction

  // Bits needed for a player index; never less than one.
  function automatic int index_width(input int num_players);
    return (num_players > 2) ? $clog2(num_players) : 1;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: signal bundle between the game engine and the match
// controller.
//   slave  : the match controller (consumes start/frame_tick/hit, drives status)
//   master : the engine / testbench side
// Signals: start, frame_tick, hit[NUM_PLAYERS] in; freeze, alive, respawn,
// lives (packed LW per player, player 0 in LSBs), scores (packed SW per
// player), round_done, round_draw, winner, state out.
//
// Protocol: there is no back-pressure anywhere. frame_tick, hit, respawn and
// round_done are single-cycle strobes that are valid exactly in the cycle they
// are high and are consumed on that clock edge; the consumer is always ready.
// start is a level, sampled only while the controller is idle or match-over.
// round_draw qualifies round_done and holds until the next round ends.
interface match_controller_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int LW          = 2,
  parameter int SW          = 2,
  parameter int IW          = 1
);
  logic                      start;
  logic                      frame_tick;
  logic [NUM_PLAYERS-1:0]    hit;
  logic                      freeze;
  logic [NUM_PLAYERS-1:0]    alive;
  logic [NUM_PLAYERS-1:0]    respawn;
  logic [NUM_PLAYERS*LW-1:0] lives;
  logic [NUM_PLAYERS*SW-1:0] scores;
  logic                      round_done;
  logic                      round_draw;
  logic [IW-1:0]             winner;
  logic [2:0]                state;

  modport slave (
    input  start, frame_tick, hit,
    output freeze, alive, respawn, lives, scores,
           round_done, round_draw, winner, state
  );

  modport master (
    output start, frame_tick, hit,
    input  freeze, alive, respawn, lives, scores,
           round_done, round_draw, winner, state
  );
endinterface

// File: rtl/match_controller_tick_timer.sv
// tick_timer: loadable down-counter that advances only on frame_tick.
// Ports: clk, reset (async, active low), frame_tick, clear (highest priority,
// forces zero), load/load_val (beats a coincident tick, so a tick on the load
// edge is not counted), done (combinational: this tick takes the count 1->0).
// A count of zero is idle and never produces done.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count_q;

  assign done = frame_tick && (count_q == W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (frame_tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: rtl/match_controller.sv
// match_controller: round/match referee for N-player tank games.
// Ports: clk, reset (async, active low), bus (match_controller_if.slave):
//   start, frame_tick, hit in; freeze, alive, respawn, lives, scores,
//   round_done, round_draw, winner, state out.
// Build option: define SUDDEN_DEATH_EN to add a ROUND_TICKS round time limit;
// at expiry the unique player with the most lives wins, a tie is a draw.
module match_controller
  import match_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int LIVES           = 3,
  parameter int WIN_SCORE       = 3,
  parameter int RESPAWN_TICKS   = DEF_RESPAWN_TICKS,
  parameter int COUNTDOWN_TICKS = DEF_COUNTDOWN_TICKS,
  parameter int ROUND_END_TICKS = DEF_ROUND_END_TICKS,
  parameter int ROUND_TICKS     = DEF_ROUND_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  match_controller_if.slave bus
);
  localparam int LW = lives_width(LIVES);
  localparam int SW = score_width(WIN_SCORE);
  localparam int IW = index_width(NUM_PLAYERS);
  localparam int RW = $clog2(RESPAWN_TICKS + 1);
  // One phase timer serves countdown, round-end hold and the round limit.
`ifdef SUDDEN_DEATH_EN
  localparam int PT = max_of(max_of(COUNTDOWN_TICKS, ROUND_END_TICKS), ROUND_TICKS);
`else
  localparam int PT = max_of(COUNTDOWN_TICKS, ROUND_END_TICKS);
`endif
  localparam int PW = $clog2(PT + 1);

  logic [2:0]                      state_q;
  logic [NUM_PLAYERS-1:0]          alive_q, respawn_q;
  logic [NUM_PLAYERS-1:0][LW-1:0]  lives_q, lives_nx;
  logic [NUM_PLAYERS-1:0][SW-1:0]  scores_q;
  logic                            round_done_q, round_draw_q;
  logic [IW-1:0]                   winner_q;

  logic                   playing, decided, round_over, match_won;
  logic [NUM_PLAYERS-1:0] acc, resp_done;
  logic [3:0]             n_surv;
  logic [LW-1:0]          top_lives;
  logic [IW-1:0]          top_idx;
  logic                   top_tie;
  logic                   phase_load, phase_clear, phase_done;
  logic [PW-1:0]          phase_val;

  assign playing = (state_q == ST_PLAYING);

  // Hit acceptance and post-hit lives. The round outcome is the unique holder
  // of the highest post-hit lives: with one survivor that is the survivor,
  // with none every player ties at zero (draw), and the same rule decides a
  // sudden-death timeout.
  always_comb begin
    acc       = '0;
    lives_nx  = lives_q;
    n_surv    = '0;
    top_lives = '0;
    top_idx   = '0;
    top_tie   = 1'b0;
    match_won = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      // Invulnerable on the respawn-pulse cycle.
      acc[i] = playing && bus.hit[i] && alive_q[i] && !respawn_q[i];
      if (acc[i] && (lives_q[i] != '0)) lives_nx[i] = lives_q[i] - 1'b1;
      if (lives_nx[i] != '0) n_surv = n_surv + 4'd1;
      if ((i == 0) || (lives_nx[i] > top_lives)) begin
        top_lives = lives_nx[i];
        top_idx   = IW'(i);
        top_tie   = 1'b0;
      end else if (lives_nx[i] == top_lives) begin
        top_tie = 1'b1;
      end
      if (scores_q[i] == SW'(WIN_SCORE)) match_won = 1'b1;
    end
  end

  assign decided = playing && (n_surv <= 4'd1);
`ifdef SUDDEN_DEATH_EN
  assign round_over = decided || (playing && phase_done);
`else
  assign round_over = decided;
`endif

  // Phase timer control mirrors the state transitions below.
  always_comb begin
    phase_load  = 1'b0;
    phase_clear = 1'b0;
    phase_val   = '0;
    case (state_q)
      ST_IDLE, ST_MATCH_OVER: if (bus.start) begin
        phase_load = 1'b1;
        phase_val  = PW'(COUNTDOWN_TICKS);
      end
      ST_COUNTDOWN: if (phase_done) begin
`ifdef SUDDEN_DEATH_EN
        phase_load = 1'b1;
        phase_val  = PW'(ROUND_TICKS);
`else
        phase_clear = 1'b1;
`endif
      end
      ST_PLAYING: if (round_over) begin
        phase_load = 1'b1;
        phase_val  = PW'(ROUND_END_TICKS);
      end
      ST_ROUND_END: if (phase_done) begin
        if (match_won) begin
          phase_clear = 1'b1;
        end else begin
          phase_load = 1'b1;
          phase_val  = PW'(COUNTDOWN_TICKS);
        end
      end
      default: phase_clear = 1'b1;
    endcase
  end

  tick_timer #(.W(PW)) u_phase (
    .clk(clk), .reset(reset), .frame_tick(bus.frame_tick),
    .clear(phase_clear), .load(phase_load), .load_val(phase_val),
    .done(phase_done)
  );

  // Respawn timers only run while a round is in play.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_resp
    tick_timer #(.W(RW)) u_resp (
      .clk(clk), .reset(reset), .frame_tick(bus.frame_tick),
      .clear(!playing || round_over),
      .load(acc[g] && (lives_nx[g] != '0)),
      .load_val(RW'(RESPAWN_TICKS)),
      .done(resp_done[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      alive_q      <= '0;
      respawn_q    <= '0;
      lives_q      <= '0;
      scores_q     <= '0;
      round_done_q <= 1'b0;
      round_draw_q <= 1'b0;
      winner_q     <= '0;
    end else begin
      respawn_q    <= '0;
      round_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_MATCH_OVER: if (bus.start) begin
          state_q  <= ST_COUNTDOWN;
          scores_q <= '0;
        end
        ST_COUNTDOWN: if (phase_done) begin
          state_q   <= ST_PLAYING;
          lives_q   <= {NUM_PLAYERS{LW'(LIVES)}};
          alive_q   <= '1;
          respawn_q <= '1;
        end
        ST_PLAYING: begin
          lives_q   <= lives_nx;
          alive_q   <= (alive_q & ~acc) | resp_done;
          respawn_q <= resp_done;
          if (round_over) begin
            state_q      <= ST_ROUND_END;
            alive_q      <= '0;
            respawn_q    <= '0;
            round_done_q <= 1'b1;
            round_draw_q <= top_tie;
            if (!top_tie) begin
              winner_q <= top_idx;
              if (scores_q[top_idx] != SW'(WIN_SCORE))
                scores_q[top_idx] <= scores_q[top_idx] + 1'b1;
            end
          end
        end
        ST_ROUND_END: if (phase_done) begin
          state_q <= match_won ? ST_MATCH_OVER : ST_COUNTDOWN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.freeze     = !playing;
  assign bus.alive      = alive_q;
  assign bus.respawn    = respawn_q;
  assign bus.lives      = lives_q;
  assign bus.scores     = scores_q;
  assign bus.round_done = round_done_q;
  assign bus.round_draw = round_draw_q;
  assign bus.winner     = winner_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed bench for match_controller with 2 players,
// LIVES=3, WIN_SCORE=2, RESPAWN_TICKS=4, COUNTDOWN_TICKS=3, ROUND_END_TICKS=2,
// ROUND_TICKS=10; frame_tick is driven every cycle unless noted.
module tb_match_controller;
  import match_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  match_controller_if #(.NUM_PLAYERS(2), .LW(2), .SW(2), .IW(1)) bus ();

  match_controller #(
    .NUM_PLAYERS(2), .LIVES(3), .WIN_SCORE(2), .RESPAWN_TICKS(4),
    .COUNTDOWN_TICKS(3), .ROUND_END_TICKS(2), .ROUND_TICKS(10)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the same point.
  task automatic step(input logic tk, input logic [1:0] h);
    bus.frame_tick = tk;
    bus.hit        = h;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.hit        = 2'b00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00);
  endtask

  task automatic start_match();
    bus.start = 1'b1;
    step(1'b1, 2'b00);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.hit = 2'b00;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({bus.state, bus.freeze, bus.alive, bus.respawn, bus.round_done, bus.round_draw, bus.winner} !== {ST_IDLE, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", {bus.state, bus.freeze, bus.alive, bus.respawn, bus.round_done, bus.round_draw, bus.winner}, {ST_IDLE, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); end
    n_checks++; if ({bus.lives, bus.scores} !== 8'h00) begin n_fail++; $display("FAIL reset_counts: got %h want 00", {bus.lives, bus.scores}); end
    reset = 1'b1;
    run(2);
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_full_round();
    start_match();
    n_checks++; if ({bus.state, bus.freeze} !== {ST_COUNTDOWN, 1'b1}) begin n_fail++; $display("FAIL fr_countdown: got %b want %b", {bus.state, bus.freeze}, {ST_COUNTDOWN, 1'b1}); end
    run(2);
    n_checks++; if (bus.state !== ST_COUNTDOWN) begin n_fail++; $display("FAIL fr_countdown_len: got %0d want %0d", bus.state, ST_COUNTDOWN); end
    run(1);
    n_checks++; if ({bus.state, bus.alive, bus.respawn, bus.lives, bus.freeze} !== {ST_PLAYING, 2'b11, 2'b11, 4'b1111, 1'b0}) begin n_fail++; $display("FAIL fr_play_entry: got %b want %b", {bus.state, bus.alive, bus.respawn, bus.lives, bus.freeze}, {ST_PLAYING, 2'b11, 2'b11, 4'b1111, 1'b0}); end
    run(1);
    step(1'b1, 2'b10);
    n_checks++; if ({bus.lives, bus.alive, bus.respawn} !== {4'b1011, 2'b01, 2'b00}) begin n_fail++; $display("FAIL fr_hit1: got %b want %b", {bus.lives, bus.alive, bus.respawn}, {4'b1011, 2'b01, 2'b00}); end
    run(3);
    n_checks++; if ({bus.alive, bus.respawn} !== {2'b01, 2'b00}) begin n_fail++; $display("FAIL fr_still_dead: got %b want %b", {bus.alive, bus.respawn}, {2'b01, 2'b00}); end
    run(1);
    n_checks++; if ({bus.alive, bus.respawn} !== {2'b11, 2'b10}) begin n_fail++; $display("FAIL fr_respawn1: got %b want %b", {bus.alive, bus.respawn}, {2'b11, 2'b10}); end
    run(1);
    step(1'b1, 2'b10);
    n_checks++; if ({bus.lives, bus.alive} !== {4'b0111, 2'b01}) begin n_fail++; $display("FAIL fr_hit2: got %b want %b", {bus.lives, bus.alive}, {4'b0111, 2'b01}); end
    run(4);
    n_checks++; if (bus.respawn !== 2'b10) begin n_fail++; $display("FAIL fr_respawn2: got %b want 10", bus.respawn); end
    run(1);
    step(1'b1, 2'b10);
    n_checks++; if ({bus.state, bus.round_done, bus.round_draw, bus.winner, bus.scores, bus.lives, bus.alive, bus.freeze} !== {ST_ROUND_END, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0011, 2'b00, 1'b1}) begin n_fail++; $display("FAIL fr_round_end: got %b want %b", {bus.state, bus.round_done, bus.round_draw, bus.winner, bus.scores, bus.lives, bus.alive, bus.freeze}, {ST_ROUND_END, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0011, 2'b00, 1'b1}); end
    run(1);
    n_checks++; if ({bus.state, bus.round_done} !== {ST_ROUND_END, 1'b0}) begin n_fail++; $display("FAIL fr_done_pulse: got %b want %b", {bus.state, bus.round_done}, {ST_ROUND_END, 1'b0}); end
    run(1);
    n_checks++; if ({bus.state, bus.scores} !== {ST_COUNTDOWN, 4'b0001}) begin n_fail++; $display("FAIL fr_next_round: got %b want %b", {bus.state, bus.scores}, {ST_COUNTDOWN, 4'b0001}); end
  endtask

  task automatic test_invulnerability();
    run(3);
    step(1'b1, 2'b11);
    n_checks++; if (bus.lives !== 4'b1111) begin n_fail++; $display("FAIL inv_start_pulse: got %b want 1111", bus.lives); end
    step(1'b1, 2'b10);
    n_checks++; if (bus.lives !== 4'b1011) begin n_fail++; $display("FAIL inv_first_hit: got %b want 1011", bus.lives); end
    run(2);
    step(1'b1, 2'b10);
    n_checks++; if (bus.lives !== 4'b1011) begin n_fail++; $display("FAIL inv_dead_hit: got %b want 1011", bus.lives); end
    step(1'b1, 2'b10);
    n_checks++; if ({bus.lives, bus.respawn} !== {4'b1011, 2'b10}) begin n_fail++; $display("FAIL inv_respawn: got %b want %b", {bus.lives, bus.respawn}, {4'b1011, 2'b10}); end
    step(1'b1, 2'b10);
    n_checks++; if ({bus.lives, bus.alive, bus.respawn} !== {4'b1011, 2'b11, 2'b00}) begin n_fail++; $display("FAIL inv_pulse_hit: got %b want %b", {bus.lives, bus.alive, bus.respawn}, {4'b1011, 2'b11, 2'b00}); end
    step(1'b1, 2'b10);
    n_checks++; if (bus.lives !== 4'b0111) begin n_fail++; $display("FAIL inv_after_pulse: got %b want 0111", bus.lives); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 2'b01);
    n_checks++; if (bus.lives !== 4'b0110) begin n_fail++; $display("FAIL sim_hit_p0: got %b want 0110", bus.lives); end
    run(5);
    n_checks++; if ({bus.alive, bus.respawn} !== {2'b11, 2'b00}) begin n_fail++; $display("FAIL sim_both_back: got %b want %b", {bus.alive, bus.respawn}, {2'b11, 2'b00}); end
    step(1'b1, 2'b01);
    run(5);
    n_checks++; if ({bus.lives, bus.alive} !== {4'b0101, 2'b11}) begin n_fail++; $display("FAIL sim_one_each: got %b want %b", {bus.lives, bus.alive}, {4'b0101, 2'b11}); end
    step(1'b1, 2'b11);
    n_checks++; if ({bus.state, bus.round_done, bus.round_draw, bus.winner, bus.scores, bus.lives} !== {ST_ROUND_END, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000}) begin n_fail++; $display("FAIL sim_draw: got %b want %b", {bus.state, bus.round_done, bus.round_draw, bus.winner, bus.scores, bus.lives}, {ST_ROUND_END, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000}); end
    run(2);
    n_checks++; if (bus.state !== ST_COUNTDOWN) begin n_fail++; $display("FAIL sim_to_countdown: got %0d want %0d", bus.state, ST_COUNTDOWN); end
  endtask

  task automatic test_match_end();
    run(4);
    step(1'b1, 2'b10);
    run(5);
    step(1'b1, 2'b10);
    run(5);
    step(1'b1, 2'b10);
    n_checks++; if ({bus.state, bus.round_draw, bus.winner, bus.scores} !== {ST_ROUND_END, 1'b0, 1'b0, 4'b0010}) begin n_fail++; $display("FAIL me_round_win: got %b want %b", {bus.state, bus.round_draw, bus.winner, bus.scores}, {ST_ROUND_END, 1'b0, 1'b0, 4'b0010}); end
    run(2);
    n_checks++; if ({bus.state, bus.freeze, bus.winner, bus.scores} !== {ST_MATCH_OVER, 1'b1, 1'b0, 4'b0010}) begin n_fail++; $display("FAIL me_match_over: got %b want %b", {bus.state, bus.freeze, bus.winner, bus.scores}, {ST_MATCH_OVER, 1'b1, 1'b0, 4'b0010}); end
    step(1'b1, 2'b11);
    run(2);
    n_checks++; if ({bus.state, bus.lives} !== {ST_MATCH_OVER, 4'b0011}) begin n_fail++; $display("FAIL me_hold: got %b want %b", {bus.state, bus.lives}, {ST_MATCH_OVER, 4'b0011}); end
    start_match();
    n_checks++; if ({bus.state, bus.scores} !== {ST_COUNTDOWN, 4'b0000}) begin n_fail++; $display("FAIL me_restart: got %b want %b", {bus.state, bus.scores}, {ST_COUNTDOWN, 4'b0000}); end
  endtask

  task automatic test_p1_wins();
    run(4);
    step(1'b1, 2'b01);
    run(5);
    step(1'b1, 2'b01);
    run(5);
    step(1'b1, 2'b01);
    n_checks++; if ({bus.state, bus.winner, bus.round_draw, bus.scores, bus.lives} !== {ST_ROUND_END, 1'b1, 1'b0, 4'b0100, 4'b1100}) begin n_fail++; $display("FAIL p1_win: got %b want %b", {bus.state, bus.winner, bus.round_draw, bus.scores, bus.lives}, {ST_ROUND_END, 1'b1, 1'b0, 4'b0100, 4'b1100}); end
    run(2);
  endtask

  task automatic test_reset_mid();
    run(4);
    step(1'b1, 2'b01);
    run(5);
    step(1'b1, 2'b01);
    run(5);
    step(1'b1, 2'b10);
    n_checks++; if ({bus.state, bus.lives} !== {ST_PLAYING, 4'b1001}) begin n_fail++; $display("FAIL rm_setup: got %b want %b", {bus.state, bus.lives}, {ST_PLAYING, 4'b1001}); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({bus.state, bus.freeze, bus.alive, bus.respawn, bus.lives, bus.scores, bus.round_done, bus.round_draw, bus.winner} !== {ST_IDLE, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rm_async: got %b want %b", {bus.state, bus.freeze, bus.alive, bus.respawn, bus.lives, bus.scores, bus.round_done, bus.round_draw, bus.winner}, {ST_IDLE, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}); end
    @(posedge clk);
    #1 reset = 1'b1;
    run(2);
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL rm_idle: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

`ifdef SUDDEN_DEATH_EN
  task automatic test_sudden_death();
    start_match();
    run(3);
    run(9);
    n_checks++; if (bus.state !== ST_PLAYING) begin n_fail++; $display("FAIL sd_before_expiry: got %0d want %0d", bus.state, ST_PLAYING); end
    run(1);
    n_checks++; if ({bus.state, bus.round_done, bus.round_draw, bus.scores} !== {ST_ROUND_END, 1'b1, 1'b1, 4'b0000}) begin n_fail++; $display("FAIL sd_draw: got %b want %b", {bus.state, bus.round_done, bus.round_draw, bus.scores}, {ST_ROUND_END, 1'b1, 1'b1, 4'b0000}); end
    run(5);
    run(1);
    step(1'b1, 2'b10);
    n_checks++; if (bus.lives !== 4'b1011) begin n_fail++; $display("FAIL sd_hit: got %b want 1011", bus.lives); end
    run(7);
    n_checks++; if (bus.state !== ST_PLAYING) begin n_fail++; $display("FAIL sd_before_expiry2: got %0d want %0d", bus.state, ST_PLAYING); end
    run(1);
    n_checks++; if ({bus.state, bus.round_draw, bus.winner, bus.scores} !== {ST_ROUND_END, 1'b0, 1'b0, 4'b0001}) begin n_fail++; $display("FAIL sd_winner: got %b want %b", {bus.state, bus.round_draw, bus.winner, bus.scores}, {ST_ROUND_END, 1'b0, 1'b0, 4'b0001}); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SUDDEN_DEATH_EN
    test_sudden_death();
`else
    test_full_round();
    test_invulnerability();
    test_simultaneous();
    test_match_end();
    test_p1_wins();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised round/match referee for N-player tank games; successor to the single-shot game-over latch.
- Receives per-tank hit strobes from the bullet units and tracks lives, respawn invulnerability, round winners and match score.
- Drives freeze/alive/respawn controls back into the tank and bullet instances.
- Sits in the engine top between the collision outputs and the tank `killed`/`game_over` inputs.

Parameters:
- NUM_PLAYERS, 2, number of tanks (2..8).
- LIVES, 3, lives per player per round (1..15).
- WIN_SCORE, 3, round wins needed to take the match (1..15).
- RESPAWN_TICKS, 60, frame ticks a hit player stays dead before respawn (>=1).
- COUNTDOWN_TICKS, 120, frame ticks of pre-round countdown (>=1).
- ROUND_END_TICKS, 90, frame ticks of post-round hold (>=1).
- ROUND_TICKS, 3600, round time limit; used only with SUDDEN_DEATH_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE and MATCH_OVER.
- frame_tick  in  1  one-cycle strobe per video frame; all timers count only on it.
- hit  in  NUM_PLAYERS  bit i = tank i struck this cycle.
- freeze  out  1  high outside PLAYING; tanks and bullets must hold.
- alive  out  NUM_PLAYERS  bit i = tank i present and vulnerable.
- respawn  out  NUM_PLAYERS  one-cycle pulse; tank i reloads its spawn position.
- lives  out  NUM_PLAYERS*LW  packed; LW = $clog2(LIVES+1); player 0 in the LSBs.
- scores  out  NUM_PLAYERS*SW  packed; SW = $clog2(WIN_SCORE+1).
- round_done  out  1  one-cycle pulse on entry to ROUND_END.
- round_draw  out  1  qualifies round_done; no winner.
- winner  out  IW  IW = max(1,$clog2(NUM_PLAYERS)); last round/match winner index.
- state  out  3  current state encoding (from the shared package).

Behaviour:
- Reset values: state=IDLE, freeze=1, alive=0, respawn=0, lives=0, scores=0, round_done=0, round_draw=0, winner=0, all timers 0.
- States and transitions:
  - IDLE: if start → COUNTDOWN; clear scores.
  - COUNTDOWN: counts COUNTDOWN_TICKS frame_ticks, then → PLAYING. On the same edge: lives=LIVES for all, alive=all ones, respawn pulses for all.
  - PLAYING: freeze=0. A hit on player i is accepted only if alive[i]. Accepted hit: lives[i]-=1, alive[i]=0. If the new lives>0, load the respawn timer with RESPAWN_TICKS. At expiry, alive[i]=1 and respawn[i] pulses one cycle.
  - Round decided when at most one player has lives>0, evaluated on post-hit values the same cycle → ROUND_END next edge, round_done pulse.
  - Exactly one survivor: winner=index, scores[winner]+=1, round_draw=0.
  - Zero survivors (simultaneous final hits): round_draw=1, scores unchanged, winner held.
  - ROUND_END: freeze=1, alive=0, respawn timers cleared. After ROUND_END_TICKS: → MATCH_OVER if any score==WIN_SCORE, else → COUNTDOWN.
  - MATCH_OVER: freeze=1; winner holds the match winner. If start → COUNTDOWN, scores cleared.
- Hit handling:
  - Simultaneous hits on different players are all accepted in one cycle.
  - A hit on a dead or respawning player is ignored.
  - A hit coincident with its own respawn pulse is ignored (invulnerable on the respawn cycle).
- Hits in any state other than PLAYING are ignored.
- Counters never wrap: lives saturate at 0 and scores saturate at WIN_SCORE.
- frame_tick coincident with a state transition counts toward the new state's timer only from the next tick.
- Reset asserted mid-round returns to the reset values immediately (asynchronous).

Optional Feature:
- SUDDEN_DEATH_EN defined:
  - A round timer counts ROUND_TICKS frame_ticks in PLAYING.
  - At expiry the round ends: the unique player with the highest lives wins; a tie at the highest value is a draw.
  - A hit-decided round on the same cycle as expiry takes priority.
- Not defined: no round timer, no ROUND_TICKS logic, rounds end only by elimination.

Decomposition:
- Package match_pkg holds:
  - state_t enum (IDLE=0, COUNTDOWN=1, PLAYING=2, ROUND_END=3, MATCH_OVER=4).
  - Width helper functions for LW, SW and IW.
  - Default tick constants.
- Sub-module tick_timer:
  - Loadable down-counter advancing on frame_tick; done pulse at zero.
  - Instantiated per player for respawn, and once shared for the countdown, round-end and round timers.

Test Plan:
- Full round, 2 players, LIVES=3:
  - start, wait countdown, then 3 accepted hits on player 1 spaced >RESPAWN_TICKS.
  - Expect lives1 3→2→1→0, two respawn[1] pulses, round_done, winner=0, scores0=1.
- Invulnerability:
  - Hit player 1, then hit it again 10 ticks later while dead.
  - Expect lives1 stays 2.
  - A hit on the respawn-pulse cycle is ignored.
- Simultaneous final hits:
  - Both players at lives=1, hit=2'b11 on one cycle.
  - Expect round_draw=1, scores unchanged, then COUNTDOWN.
- Match end, WIN_SCORE=2:
  - Player 0 wins two rounds.
  - Expect MATCH_OVER, winner=0, freeze=1.
  - Then start → scores=0, COUNTDOWN.
- Reset mid-PLAYING, with lives=1/2:
  - Drive reset low between clock edges.
  - Expect all outputs at reset values immediately, state=IDLE.
- SUDDEN_DEATH_EN, ROUND_TICKS=10:
  - No hits, timer expires.
  - Expect round_draw=1.
  - Repeat with one hit on player 1 first: expect winner=0.
